// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter slice:
// default widths, the writeback-source tag and the round-robin pick helper.
package rf_wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  // Which requester a registered writeback came from.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

  // Round-robin pick for the load port: a lone load wins, and on a tie the
  // load wins only if the ALU was the last requester granted.
  function automatic logic pick_ld(input logic alu_valid,
                                   input logic ld_valid,
                                   input logic last_ld);
    return ld_valid && (!alu_valid || !last_ld);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register.
// A load issue sets the bit for its destination; the load's writeback
// clears it. A set and a clear to the same register on one edge leave the
// bit set, because the newer load is still outstanding. r0 is never tracked.
module rf_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_addr,
  output logic [(1<<AW)-1:0]   busy_vec
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Decode set and clear requests into one-hot masks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_addr != '0)) set_mask[set_addr] = 1'b1;
    if (clr_en)                     clr_mask[clr_addr] = 1'b1;
  end

  // Clear first, then set, so a set wins a same-edge collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      busy_vec <= (busy_vec & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Two requesters (ALU, load) share one register-file write port under
// round-robin arbitration; the winner is registered and presented on
// rf_we/rf_waddr/rf_wdata one cycle after the handshake. Writes to r0 are
// accepted but never drive rf_we. A pending-load scoreboard (rf_scoreboard)
// produces the decode-stage hazard stall.
// Build option: define RF_WB_FWD_EN to add writeback-to-decode forwarding
// outputs (fwd1_*/fwd2_*), which also let a committing load write mask its
// own busy term out of stall.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [AW-1:0]        alu_waddr,
  input  logic [XLEN-1:0]      alu_wdata,
  output logic                 alu_ready,
  input  logic                 ld_valid,
  input  logic [AW-1:0]        ld_waddr,
  input  logic [XLEN-1:0]      ld_wdata,
  output logic                 ld_ready,
  input  logic                 ld_issue,
  input  logic [AW-1:0]        ld_issue_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 stall,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [(1<<AW)-1:0]   busy_vec
`ifdef RF_WB_FWD_EN
  ,
  output logic                 fwd1_hit,
  output logic [XLEN-1:0]      fwd1_data,
  output logic                 fwd2_hit,
  output logic [XLEN-1:0]      fwd2_data
`endif
);

  logic    last_ld;     // 1: load was granted last, 0: ALU was granted last
  logic    alu_xfer;
  logic    ld_xfer;
  wb_src_e rf_src;      // source of the write currently on rf_we
  logic    mask1;
  logic    mask2;

  // Grants depend only on the valids and the round-robin pointer.
  assign ld_ready  = pick_ld(alu_valid, ld_valid, last_ld);
  assign alu_ready = alu_valid && !ld_ready;
  assign alu_xfer  = alu_valid && alu_ready;
  assign ld_xfer   = ld_valid && ld_ready;

  // Remember which requester won the most recent transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ld <= 1'b0;
    end else if (alu_xfer) begin
      last_ld <= 1'b0;
    end else if (ld_xfer) begin
      last_ld <= 1'b1;
    end
  end

  // Register the granted write; r0 transfers are consumed without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      // NOTE: data registers usually skip reset; this one is reset because its value is observable during reset.
      rf_wdata <= '0;
      rf_src   <= SRC_ALU;
    end else begin
      rf_we <= 1'b0;
      if (ld_xfer && (ld_waddr != '0)) begin
        rf_we    <= 1'b1;
        rf_waddr <= ld_waddr;
        rf_wdata <= ld_wdata;
        rf_src   <= SRC_LD;
      end else if (alu_xfer && (alu_waddr != '0)) begin
        rf_we    <= 1'b1;
        rf_waddr <= alu_waddr;
        rf_wdata <= alu_wdata;
        rf_src   <= SRC_ALU;
      end
    end
  end

  rf_scoreboard #(
    .AW (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (ld_issue),
    .set_addr (ld_issue_rd),
    .clr_en   (rf_we && (rf_src == SRC_LD)),
    .clr_addr (rf_waddr),
    .busy_vec (busy_vec)
  );

`ifdef RF_WB_FWD_EN
  // The committing write is visible to decode, so its busy term is moot.
  assign fwd1_hit  = rf_we && (rf_waddr == rs1) && (rs1 != '0);
  assign fwd2_hit  = rf_we && (rf_waddr == rs2) && (rs2 != '0);
  assign fwd1_data = rf_wdata;
  assign fwd2_data = rf_wdata;
  assign mask1     = fwd1_hit;
  assign mask2     = fwd2_hit;
`else
  assign mask1     = 1'b0;
  assign mask2     = 1'b0;
`endif

  assign stall = ((rs1 != '0) && busy_vec[rs1] && !mask1) ||
                 ((rs2 != '0) && busy_vec[rs2] && !mask2);

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter AW, default 5, meaning register address width (2**AW registers).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports alu_valid in 1, alu_waddr in AW, alu_wdata in XLEN, alu_ready out 1: the ALU writeback requester.
REQ-006 SHALL have ports ld_valid in 1, ld_waddr in AW, ld_wdata in XLEN, ld_ready out 1: the load writeback requester.
REQ-007 SHALL have ports ld_issue in 1, ld_issue_rd in AW: a load is dispatched and its destination becomes pending.
REQ-008 SHALL have ports rs1 in AW, rs2 in AW, stall out 1: decode-stage source operands and hazard stall.
REQ-009 SHALL have ports rf_we out 1, rf_waddr out AW, rf_wdata out XLEN: drive the register-file write port.
REQ-010 SHALL have port busy_vec out 2**AW: the scoreboard, bit n set while register n awaits a load.

Function
REQ-011 SHALL grant at most one requester per cycle; ready is combinational, from valid and the round-robin pointer; transfer occurs when valid && ready.
REQ-012 SHALL use round-robin arbitration: when both are valid, grant the requester not granted last; a lone valid requester is granted immediately.
REQ-013 SHALL register the granted request: rf_we/rf_waddr/rf_wdata appear exactly one cycle after the transfer, with rf_we high for exactly one cycle per transfer.
REQ-014 SHALL consume a transfer with waddr == 0 without asserting rf_we.
REQ-015 SHALL set busy_vec[ld_issue_rd] at the clock edge where ld_issue is high, unless ld_issue_rd == 0.
REQ-016 SHALL clear busy_vec[n] at the clock edge where rf_we is high with rf_waddr == n and that write originated on the load path; ALU-path writes do not clear busy bits.
REQ-017 SHALL give set priority when a set and a clear hit the same register on the same edge.
REQ-018 SHALL drive stall = (rs1 != 0 && busy_vec[rs1]) || (rs2 != 0 && busy_vec[rs2]), combinationally.
REQ-019 SHALL require requesters to hold valid and payload stable until ready; behaviour otherwise is undefined.

Reset
REQ-020 SHALL, while rst is high, force rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, and set the round-robin pointer to "ALU granted last" (load wins the first tie).
REQ-021 SHALL discard a registered write in flight when rst asserts; it never reaches rf_we.

Configuration
REQ-022 SHALL, with RF_WB_FWD_EN defined, add the outputs fwd1_hit, fwd1_data, fwd2_hit, and fwd2_data. fwdN_hit = rf_we && rf_waddr == rsN && rsN != 0, and fwdN_data = rf_wdata. When fwdN_hit is set, the busy term for rsN is masked out of stall.
REQ-023 SHALL, without RF_WB_FWD_EN, omit those ports; stall then follows REQ-018 exactly and deasserts only the cycle after the load write commits.

Structure
REQ-024 SHALL place XLEN/AW defaults and the write-source enum (SRC_ALU, SRC_LD) in the shared package rf_wb_pkg.
REQ-025 SHALL implement the busy vector and its set/clear logic in the sub-module rf_scoreboard; arbitration and the output register live in the top module.

Verification
REQ-026 SHALL verify: alu_valid alone, waddr=3, wdata=0xDEADBEEF -> alu_ready same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF.
REQ-027 SHALL verify: alu_valid and ld_valid both held for 4 cycles after reset -> grant order LD, ALU, LD, ALU; one rf_we per cycle.
REQ-028 SHALL verify: ld_issue rd=5, then rs1=5 -> stall=1 until the cycle after the load write to r5 commits; rs1=0 never stalls.
REQ-029 SHALL verify: ld_issue rd=7 on the same edge that a load write to r7 commits -> busy_vec[7] remains 1.
REQ-030 SHALL verify: transfer with waddr=0 -> no rf_we; rst asserted with a write in flight -> rf_we=0 and busy_vec=0.
REQ-031 SHALL verify, with RF_WB_FWD_EN: load write to r9 committing while rs2=9 -> fwd2_hit=1, fwd2_data=wdata, stall=0 that cycle.
